// File: rtl/sec08_queues_arb_pkg.sv
// ---------------------------------------------------------------------------
// sec08_queues_arb_pkg
// Shared definitions for the round-robin arbitrated queue slice.
//   - idxWidth()       : width of a requester index for a given requester count
//   - STATS_CNT_W      : width of each per-requester grant statistics counter
//   - VC_QUEUE_*       : queue flavour selectors understood by vc_Queue
// No ports (package only).
// ---------------------------------------------------------------------------
package sec08_queues_arb_pkg;

  localparam int STATS_CNT_W = 16;

  localparam int VC_QUEUE_NORMAL = 0;
  localparam int VC_QUEUE_PIPE   = 1;
  localparam int VC_QUEUE_BYPASS = 2;

  // Index width never drops below one bit so that degenerate sizes still
  // produce a legal vector declaration.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sec08_queues_rr_arb_queue_vc_queue.sv
// ---------------------------------------------------------------------------
// vc_Queue
// Circular-buffer val/rdy queue. With p_type containing VC_QUEUE_BYPASS an
// incoming message is visible on the dequeue side in the same cycle when the
// queue is empty, and a full queue accepts a new message in the same cycle
// that its head is dequeued.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   enq_val_i/rdy_o   : enqueue handshake, enq_msg_i payload
//   deq_val_o/rdy_i   : dequeue handshake, deq_msg_o payload
// ---------------------------------------------------------------------------
module vc_Queue
  import sec08_queues_arb_pkg::*;
#(
  parameter int p_type      = VC_QUEUE_NORMAL,
  parameter int p_msg_nbits = 32,
  parameter int p_num_msgs  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val_i,
  output logic                   enq_rdy_o,
  input  logic [p_msg_nbits-1:0] enq_msg_i,
  output logic                   deq_val_o,
  input  logic                   deq_rdy_i,
  output logic [p_msg_nbits-1:0] deq_msg_o
);

  localparam int AW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam int CW = $clog2(p_num_msgs + 1);
  localparam bit BYPASS = (p_type & VC_QUEUE_BYPASS) != 0;

  logic [p_msg_nbits-1:0] mem_q [p_num_msgs];
  logic [AW-1:0]          wrPtr_q, wrPtr_d;
  logic [AW-1:0]          rdPtr_q, rdPtr_d;
  logic [CW-1:0]          count_q, count_d;

  logic empty, full, doEnq, doDeq, passThru, store, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(p_num_msgs));

  // A full bypass queue can still take a message if the head leaves this
  // cycle; an empty bypass queue forwards the enqueue side straight through.
  assign enq_rdy_o = !full || (BYPASS && deq_rdy_i);
  assign deq_val_o = !empty || (BYPASS && enq_val_i);
  assign deq_msg_o = (BYPASS && empty) ? enq_msg_i : mem_q[rdPtr_q];

  assign doEnq    = enq_val_i && enq_rdy_o;
  assign doDeq    = deq_val_o && deq_rdy_i;
  assign passThru = BYPASS && empty && doEnq && doDeq;
  assign store    = doEnq && !passThru;
  assign pop      = doDeq && !passThru;

  // Next-state for the pointers and occupancy; a message that bypasses the
  // storage entirely leaves all of them untouched.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (store) begin
      wrPtr_d = (wrPtr_q == AW'(p_num_msgs - 1)) ? '0 : wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == AW'(p_num_msgs - 1)) ? '0 : rdPtr_q + AW'(1);
    end
    count_d = count_q + CW'(store) - CW'(pop);
  end

  // Control state is cleared on reset, which also discards anything stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; the occupancy count decides what is live.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wrPtr_q] <= enq_msg_i;
    end
  end

endmodule

// File: rtl/sec08_queues_rr_arb_queue.sv
// ---------------------------------------------------------------------------
// sec08_queues_rr_arb_queue
// Round-robin arbiter merging p_nreqs val/rdy requesters into one output
// stream through a shared bypass queue. Each output message carries the
// index of its source requester in the MSBs.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   istream_*    : per-requester val/rdy/msg (requester i at msg[i*W +: W])
//   ostream_*    : merged output, msg = {src_idx, payload}
//   grant_count  : only with SEC08_QUEUES_RR_ARB_STATS_EN defined; one 16-bit
//                  saturating enqueue counter per requester
// Optional feature macro: SEC08_QUEUES_RR_ARB_STATS_EN
// ---------------------------------------------------------------------------
module sec08_queues_rr_arb_queue
  import sec08_queues_arb_pkg::*;
#(
  parameter int p_nreqs     = 4,
  parameter int p_msg_nbits = 32,
  parameter int p_num_msgs  = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [p_nreqs-1:0]                           istream_val,
  output logic [p_nreqs-1:0]                           istream_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0]               istream_msg,
  output logic                                         ostream_val,
  input  logic                                         ostream_rdy,
  output logic [idxWidth(p_nreqs)+p_msg_nbits-1:0]     ostream_msg
`ifdef SEC08_QUEUES_RR_ARB_STATS_EN
  ,
  output logic [p_nreqs*STATS_CNT_W-1:0]               grant_count
`endif
);

  localparam int IW = idxWidth(p_nreqs);
  localparam int OW = IW + p_msg_nbits;

  logic [IW-1:0]      prio_q, prio_d;
  logic [p_nreqs-1:0] grant;
  logic [IW-1:0]      grantIdx;
  logic [IW-1:0]      scanIdx;
  logic               found;

  logic          enqVal, enqRdy, deqVal, deqRdy;
  logic [OW-1:0] enqMsg;

  // Scan requesters starting at the priority pointer; index arithmetic wraps
  // naturally because p_nreqs is a power of two. Only the first valid
  // requester found is granted.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    scanIdx  = '0;
    for (int k = 0; k < p_nreqs; k++) begin
      scanIdx = prio_q + IW'(k);
      if (!found && istream_val[scanIdx]) begin
        found           = 1'b1;
        grant[scanIdx]  = 1'b1;
        grantIdx        = scanIdx;
      end
    end
  end

  // Ready is only offered to the granted requester, and nobody sees ready
  // or output valid while reset is held.
  assign istream_rdy = reset ? '0 : (grant & {p_nreqs{enqRdy}});
  assign enqVal      = |(istream_val & istream_rdy);
  assign enqMsg      = {grantIdx, istream_msg[grantIdx*p_msg_nbits +: p_msg_nbits]};
  assign deqRdy      = ostream_rdy & ~reset;
  assign ostream_val = deqVal & ~reset;

  vc_Queue #(
    .p_type      (VC_QUEUE_BYPASS),
    .p_msg_nbits (OW),
    .p_num_msgs  (p_num_msgs)
  ) sharedQueue (
    .clk       (clk),
    .reset     (reset),
    .enq_val_i (enqVal),
    .enq_rdy_o (enqRdy),
    .enq_msg_i (enqMsg),
    .deq_val_o (deqVal),
    .deq_rdy_i (deqRdy),
    .deq_msg_o (ostream_msg)
  );

  // Priority moves just past the requester that actually enqueued; idle and
  // back-pressured cycles leave it where it is.
  always_comb begin
    prio_d = enqVal ? (grantIdx + IW'(1)) : prio_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

`ifdef SEC08_QUEUES_RR_ARB_STATS_EN
  logic [STATS_CNT_W-1:0] grantCnt_q [p_nreqs];

  // One saturating counter per requester, bumped on that requester's enqueue.
  always_ff @(posedge clk) begin
    for (int i = 0; i < p_nreqs; i++) begin
      if (reset) begin
        grantCnt_q[i] <= '0;
      end else if (enqVal && grant[i] && (grantCnt_q[i] != '1)) begin
        grantCnt_q[i] <= grantCnt_q[i] + STATS_CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < p_nreqs; g++) begin : g_statsOut
    assign grant_count[g*STATS_CNT_W +: STATS_CNT_W] = grantCnt_q[g];
  end
`endif

endmodule
